// File: rtl/button_event.sv
// Button gesture classifier: turns each debounced button channel into
// short-press, long-press and double-click event pulses. A single 1 ms tick
// prescaler is shared by all channels so each channel needs only a narrow
// millisecond counter.

module button_event_ch #(
   parameter int CW        = 10,
   parameter int LONG_MS   = 1000,
   parameter int DOUBLE_MS = 300
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic key_level_i,
   input  logic key_rise_i,
   output logic short_o,
   output logic long_o,
   output logic dbl_o,
   output logic busy_o
);

   typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

   localparam logic [CW-1:0] LONG_C = CW'(LONG_MS);
   localparam logic [CW-1:0] DBL_C  = CW'(DOUBLE_MS);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            short_q, long_q, dbl_q, busy_q;

   // Gesture FSM with its ms counter and registered event pulses.
   // The counter assignment in each transition branch overrides the tick
   // increment above it, so every state change restarts timing from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         if (tick_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (key_rise_i) begin
                  state_q <= PRESS1;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            PRESS1: begin
               // release wins over the long threshold in the same cycle
               if (!key_level_i) begin
                  state_q <= WAIT2;
                  cnt_q   <= '0;
               end else if (cnt_q == LONG_C) begin
                  long_q  <= 1'b1;
                  state_q <= LONG;
                  cnt_q   <= '0;
               end
            end
            LONG: begin
               if (!key_level_i) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            WAIT2: begin
               // a second press wins over the double-click timeout
               if (key_rise_i) begin
                  state_q <= PRESS2;
                  cnt_q   <= '0;
               end else if (cnt_q == DBL_C) begin
                  short_q <= 1'b1;
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            PRESS2: begin
               if (!key_level_i) begin
                  dbl_q   <= 1'b1;
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign short_o = short_q;
   assign long_o  = long_q;
   assign dbl_o   = dbl_q;
   assign busy_o  = busy_q;

endmodule

module button_event #(
   parameter int BUTTON_WIDTH = 2,
   parameter int SYS_CLOCK    = 100_000_000,
   parameter int LONG_MS      = 1000,
   parameter int DOUBLE_MS    = 300
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [BUTTON_WIDTH-1:0] key_level,
   input  logic [BUTTON_WIDTH-1:0] key_rise,
   output logic [BUTTON_WIDTH-1:0] short_press,
   output logic [BUTTON_WIDTH-1:0] long_press,
   output logic [BUTTON_WIDTH-1:0] double_click,
   output logic [BUTTON_WIDTH-1:0] busy
);

   localparam int TICK_DIV = SYS_CLOCK / 1000;
   localparam int PW       = $clog2(TICK_DIV);
   localparam int MAX_MS   = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
   localparam int CW       = $clog2(MAX_MS + 1);

   localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q;
   logic          tick;

   assign tick = (pre_q == TICK_MAX);

   // Free-running 1 ms prescaler; only reset clears it, so a gesture can
   // start anywhere in a tick period (timing resolution -1 ms / +0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + 1'b1;
   end

   for (genvar g = 0; g < BUTTON_WIDTH; g++) begin : g_ch
      button_event_ch #(
         .CW        (CW),
         .LONG_MS   (LONG_MS),
         .DOUBLE_MS (DOUBLE_MS)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick_i      (tick),
         .key_level_i (key_level[g]),
         .key_rise_i  (key_rise[g]),
         .short_o     (short_press[g]),
         .long_o      (long_press[g]),
         .dbl_o       (double_click[g]),
         .busy_o      (busy[g])
      );
   end

endmodule
